sm_alu_bcd: RTL and testbench
=============================

Name: sm_alu_bcd

Overview:
Parametrised sign-magnitude arithmetic unit that generalises the calculator datapath to W-bit magnitudes. It adds a sequential multiply mode and a start/busy/done handshake. A start pulse captures two sign-magnitude operands and an opcode, runs a multi-cycle execute phase, then converts the result to BCD with a sequential double-dabble. Output registers feed the magnitude indicator and seven-segment decoders downstream.

Parameters:
W, 3, operand magnitude width in bits (W >= 2).
DIGITS, 2, number of BCD digits on bcd; must satisfy 10^DIGITS > (2^W-1)^2.

Ports:
clk  input  1  clock; all logic on rising edge.
ar  input  1  reset, synchronous, active-high.
start  input  1  request; sampled only in IDLE.
op  input  2  00 add, 01 sub, 10 mul, 11 reserved.
a_sign  input  1  operand A sign (1 = negative).
a_mag  input  W  operand A magnitude.
b_sign  input  1  operand B sign.
b_mag  input  W  operand B magnitude.
busy  output  1  high from the cycle after start is accepted through the cycle before done.
done  output  1  one-cycle pulse; result outputs are valid and updated in this cycle.
err  output  1  last accepted request used reserved op.
res_sign  output  1  result sign.
res_mag  output  2W  result magnitude.
bcd  output  4*DIGITS  packed BCD of res_mag, digit 0 in bits [3:0].

Behaviour:
- Reset (ar=1 at clk edge): FSM goes to IDLE. busy, done, err, res_sign, res_mag and bcd all become 0. This has priority over every other event, including mid-operation.
- FSM states: IDLE, EXEC, CONV, DONE.
- IDLE + start (at cycle t): register operands and op, clear err, go to EXEC. If op=11: set err, go directly to DONE; result outputs keep their previous values.
- EXEC, add/sub: 1 cycle. Sub is add with b_sign inverted.
  - Equal signs: magnitude = a+b, sign = common sign.
  - Unequal signs: magnitude = larger minus smaller, sign = sign of larger magnitude.
  - Equal magnitudes: +0.
- EXEC, mul: W cycles of shift-add over b_mag bits, LSB first. sign = a_sign XOR b_sign.
- CONV: double-dabble over the 2W-bit magnitude, exactly 2W cycles. Add-3 correction applies to each digit >= 5 before each shift.
- DONE: 1 cycle. done=1; res_sign, res_mag and bcd are registered so they are visible in this cycle. Then return to IDLE.
- Latency: add/sub done at t+2+2W; mul done at t+1+W+2W; reserved op done at t+1. For W=3: t+8, t+10, t+1.
- Zero normalisation: any zero magnitude result has res_sign=0. Inputs of -0 are treated as +0.
- Add width: the sum is at most 2^(W+1)-2 and fits in 2W bits; no overflow is possible.
- start while busy or in DONE is ignored, not queued. Operand input changes during busy have no effect.
- Outputs hold their last values in IDLE indefinitely. err holds until the next accepted start.
- busy=0 in IDLE and DONE, 1 in EXEC and CONV.

Decomposition:
- Package sm_alu_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_MUL, OP_RSV.
  - FSM state enum.
  - Helper function for the sign-magnitude add/compare.
- One sub-module, bcd_dabble, parametrised by BITS=2W and DIGITS.
  - Ports: clk, ar, start, bin, busy, done, bcd.
  - Owns the CONV phase. Top-level FSM waits on its done.
- Multiplier shift-add stays inline in the top module.

Test Plan:
1. Reset: hold ar=1 two cycles with start=1 -> all outputs 0, busy 0; first cycle after release still idle unless start is sampled.
2. Add: start op=00, A=+5, B=-7 (W=3) at t -> busy t+1..t+7, done=1 at t+8 only; res_sign=1, res_mag=2, bcd=8'h02. Then A=+7, B=+7 -> res_mag=14, bcd=8'h14.
3. Sub/zero: op=01, A=-3, B=-3 -> res_sign=0, res_mag=0, bcd=8'h00. Also A=-0, B=+0 add -> +0.
4. Mul and ignored start: op=10, A=-7, B=+7 -> done at t+10, res_sign=1, res_mag=49, bcd=8'h49. Extra start pulses at t+3 and t+10 are ignored (busy stays 0 at t+11). A=+6, B=-0 -> +0.
5. Reserved op: after test 4, op=11 at t -> done and err=1 at t+1; res_mag still 49. Next valid add clears err at t+1.
6. Reset mid-operation: mul started, ar=1 at t+4 -> by t+5 busy=0, res_mag=0, bcd=0, no done pulse. A following add of +1 + +2 gives res_mag=3 at the normal latency.

Source files
------------

// File: rtl/sm_alu_pkg.sv
// Shared definitions for the sign-magnitude ALU with BCD conversion:
// opcodes, controller state encoding, debug view and the add/sub sign helper.
package sm_alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CONV = 2'd2,
      ST_DONE = 2'd3
   } sm_state_e;

   // Observation point for checkers: controller state plus converter activity.
   typedef struct packed {
      sm_state_e state;
      logic      dab_busy;
   } sm_dbg_t;

   // Outcome of a sign-magnitude add once B's effective sign is known.
   typedef struct packed {
      logic neg;  // raw result sign (before zero normalisation)
      logic sub;  // magnitudes are subtracted (larger minus smaller)
   } sm_plan_t;

   // Equal signs add magnitudes and keep the sign; unequal signs subtract
   // the smaller magnitude from the larger and take the larger's sign.
   function automatic sm_plan_t sm_plan(input logic a_sign,
                                        input logic b_sign,
                                        input logic a_ge_b);
      sm_plan_t p;
      p.sub = a_sign ^ b_sign;
      p.neg = p.sub ? (a_ge_b ? a_sign : b_sign) : a_sign;
      return p;
   endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Sequential double-dabble binary-to-BCD converter. A start pulse while idle
// loads the binary value and performs the first step in the same edge; the
// remaining BITS-1 steps follow, and done pulses the cycle after the last one.
module bcd_dabble #(
   parameter int BITS   = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  ar,
   input  logic                  start,
   input  logic [BITS-1:0]       bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BITS);

   logic [BITS-1:0]  bin_q, bin_d, src_bin;
   logic [BCD_W-1:0] bcd_q, bcd_d, src_bcd, fix;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;

   // One conversion step: add 3 to every digit >= 5, then shift {bcd, bin} left.
   always_comb begin
      src_bcd = busy_q ? bcd_q : '0;
      src_bin = busy_q ? bin_q : bin;
      fix     = src_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (src_bcd[4*d +: 4] >= 4'd5) begin
            fix[4*d +: 4] = src_bcd[4*d +: 4] + 4'd3;
         end
      end
      {bcd_d, bin_d} = {fix, src_bin} << 1;
   end

   // Step sequencer: start loads and steps once, then BITS-1 further steps.
   always_ff @(posedge clk) begin
      if (ar) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BITS - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end else if (start) begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/sm_alu_bcd.sv
// Sign-magnitude add/sub/multiply unit with sequential BCD conversion.
// Handshake: start is sampled only in IDLE; once accepted, busy is high for
// every EXEC/CONV cycle, then done pulses for exactly one cycle with
// res_sign/res_mag/bcd/err already valid. Starts outside IDLE are dropped.
module sm_alu_bcd
   import sm_alu_pkg::*;
#(
   parameter int W      = 3,
   parameter int DIGITS = 2
) (
   input  logic                 clk,
   input  logic                 ar,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic                 a_sign,
   input  logic [W-1:0]         a_mag,
   input  logic                 b_sign,
   input  logic [W-1:0]         b_mag,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 res_sign,
   output logic [2*W-1:0]       res_mag,
   output logic [4*DIGITS-1:0]  bcd,
   output sm_dbg_t              dbg
);

   localparam int MAG_W = 2 * W;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(W);

   sm_state_e        state_q;
   logic [1:0]       op_q;
   logic             a_sign_q, b_sign_q;
   logic [W-1:0]     a_mag_q, b_mag_q, mplier_q;
   logic [MAG_W-1:0] acc_q, mcand_q, work_mag_q;
   logic             work_sign_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, err_q, res_sign_q;
   logic [MAG_W-1:0] res_mag_q;
   logic [BCD_W-1:0] bcd_q;

   logic             b_eff, a_ge_b, exec_neg, exec_sign, exec_last, dab_start;
   sm_plan_t         plan;
   logic [MAG_W-1:0] add_mag, acc_d, exec_mag;
   logic             dab_busy, dab_done;
   logic [BCD_W-1:0] dab_bcd;

   // Execute datapath: add/sub result, next multiplier partial sum, and the
   // normalised value handed to the converter on the last EXEC cycle.
   always_comb begin
      b_eff  = b_sign_q ^ (op_q == OP_SUB);
      a_ge_b = a_mag_q >= b_mag_q;
      plan   = sm_plan(a_sign_q, b_eff, a_ge_b);
      if (!plan.sub) begin
         add_mag = MAG_W'(a_mag_q) + MAG_W'(b_mag_q);
      end else if (a_ge_b) begin
         add_mag = MAG_W'(a_mag_q - b_mag_q);
      end else begin
         add_mag = MAG_W'(b_mag_q - a_mag_q);
      end
      acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      if (op_q == OP_MUL) begin
         exec_mag  = acc_d;
         exec_neg  = a_sign_q ^ b_sign_q;
         exec_last = (cnt_q == CNT_W'(W - 1));
      end else begin
         exec_mag  = add_mag;
         exec_neg  = plan.neg;
         exec_last = 1'b1;
      end
      // A zero magnitude is always reported as +0.
      exec_sign = exec_neg & (exec_mag != '0);
      dab_start = (state_q == ST_EXEC) && exec_last;
   end

   bcd_dabble #(
      .BITS   (MAG_W),
      .DIGITS (DIGITS)
   ) u_dabble (
      .clk   (clk),
      .ar    (ar),
      .start (dab_start),
      .bin   (exec_mag),
      .busy  (dab_busy),
      .done  (dab_done),
      .bcd   (dab_bcd)
   );

   // Controller FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (ar) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         a_sign_q    <= 1'b0;
         a_mag_q     <= '0;
         b_sign_q    <= 1'b0;
         b_mag_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         cnt_q       <= '0;
         work_mag_q  <= '0;
         work_sign_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         res_sign_q  <= 1'b0;
         res_mag_q   <= '0;
         bcd_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  a_sign_q <= a_sign;
                  a_mag_q  <= a_mag;
                  b_sign_q <= b_sign;
                  b_mag_q  <= b_mag;
                  mplier_q <= b_mag;
                  mcand_q  <= MAG_W'(a_mag);
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  err_q    <= (op == OP_RSV);
                  if (op == OP_RSV) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_EXEC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               if (op_q == OP_MUL) begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + CNT_W'(1);
               end
               if (exec_last) begin
                  work_mag_q  <= exec_mag;
                  work_sign_q <= exec_sign;
                  state_q     <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (dab_done) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  res_sign_q <= work_sign_q;
                  res_mag_q  <= work_mag_q;
                  bcd_q      <= dab_bcd;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign res_sign     = res_sign_q;
   assign res_mag      = res_mag_q;
   assign bcd          = bcd_q;
   assign dbg.state    = state_q;
   assign dbg.dab_busy = dab_busy;

endmodule

// File: tb/tb_sm_alu_bcd.sv
// Self-checking bench for sm_alu_bcd: directed vector table, randomized
// operations against a signed-integer reference model, and hand sequences
// for reset, ignored starts, reserved opcode and reset during an operation.
module tb_sm_alu_bcd;
   import sm_alu_pkg::*;

   localparam int W      = 3;
   localparam int DIGITS = 2;
   localparam int MAG_W  = 2 * W;
   localparam int BCD_W  = 4 * DIGITS;

   logic             clk = 1'b0;
   logic             ar, start;
   logic [1:0]       op;
   logic             a_sign, b_sign;
   logic [W-1:0]     a_mag, b_mag;
   logic             busy, done, err, res_sign;
   logic [MAG_W-1:0] res_mag;
   logic [BCD_W-1:0] bcd;
   sm_dbg_t          dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Clock
   always #5 clk = ~clk;

   sm_alu_bcd #(.W(W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .ar       (ar),
      .start    (start),
      .op       (op),
      .a_sign   (a_sign),
      .a_mag    (a_mag),
      .b_sign   (b_sign),
      .b_mag    (b_mag),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .res_sign (res_sign),
      .res_mag  (res_mag),
      .bcd      (bcd),
      .dbg      (dbg)
   );

   typedef struct {
      logic [1:0]       op;
      logic             as;
      logic [W-1:0]     am;
      logic             bs;
      logic [W-1:0]     bm;
      bit               poke;
      logic             es;
      logic [MAG_W-1:0] em;
      logic [BCD_W-1:0] eb;
      logic             ee;
   } vec_t;

   vec_t vecs[$];

   // Reference state: result outputs visible before the next operation.
   logic             last_sign;
   logic [MAG_W-1:0] last_mag;
   logic [BCD_W-1:0] last_bcd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [1:0] o, input logic as, input int am, input logic bs,
                          input int bm, input bit poke, input logic es, input int em,
                          input int eb, input logic ee);
      vec_t v;
      v.op = o; v.as = as; v.am = W'(am); v.bs = bs; v.bm = W'(bm); v.poke = poke;
      v.es = es; v.em = MAG_W'(em); v.eb = BCD_W'(eb); v.ee = ee;
      vecs.push_back(v);
   endtask

   // Reference model: plain signed arithmetic and decimal digit extraction.
   function automatic void model(input logic [1:0] o, input logic as, input logic [W-1:0] am,
                                 input logic bs, input logic [W-1:0] bm, output logic es,
                                 output logic [MAG_W-1:0] em, output logic [BCD_W-1:0] eb,
                                 output logic ee);
      int va, vb, r, t;
      if (o == 2'b11) begin
         es = last_sign; em = last_mag; eb = last_bcd; ee = 1'b1;
         return;
      end
      va = as ? -int'(am) : int'(am);
      vb = bs ? -int'(bm) : int'(bm);
      if (o == 2'b00)      r = va + vb;
      else if (o == 2'b01) r = va - vb;
      else                 r = va * vb;
      es = (r < 0);
      t  = (r < 0) ? -r : r;
      em = MAG_W'(t);
      eb = '0;
      for (int d = 0; d < DIGITS; d++) begin
         eb[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      ee = 1'b0;
   endfunction

   function automatic int exp_lat(input logic [1:0] o);
      if (o == 2'b11) return 1;
      if (o == 2'b10) return 1 + 3 * W;
      return 2 + 2 * W;
   endfunction

   task automatic scramble();
      op     = 2'($urandom_range(0, 3));
      a_sign = 1'($urandom_range(0, 1));
      b_sign = 1'($urandom_range(0, 1));
      a_mag  = W'($urandom_range(0, (1 << W) - 1));
      b_mag  = W'($urandom_range(0, (1 << W) - 1));
   endtask

   // Driver: pulse start, then follow the operation cycle by cycle (bounded).
   // Returns at the negedge of the done cycle, with done_cyc counted from t.
   task automatic run_op(input logic [1:0] o, input logic as, input logic [W-1:0] am,
                         input logic bs, input logic [W-1:0] bm, input bit poke,
                         output int done_cyc, output int busy_bad, output logic err1);
      @(negedge clk);
      op = o; a_sign = as; a_mag = am; b_sign = bs; b_mag = bm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      done_cyc = -1;
      busy_bad = 0;
      err1     = err;
      for (int c = 1; c <= 64; c++) begin
         if (done) begin
            done_cyc = c;
            if (busy) busy_bad++;
            break;
         end
         if (!busy) busy_bad++;
         start = poke && (c == 3);
         if (c % 2 == 0) scramble();
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int dc, bb, pulses;
      logic e1;
      run_op(v.op, v.as, v.am, v.bs, v.bm, v.poke, dc, bb, e1);
      check({tag, " latency"}, dc, exp_lat(v.op));
      check({tag, " busy"}, bb, 0);
      check({tag, " err_t1"}, e1, v.ee);
      check({tag, " err"}, err, v.ee);
      check({tag, " res_sign"}, res_sign, v.es);
      check({tag, " res_mag"}, res_mag, v.em);
      check({tag, " bcd"}, bcd, v.eb);
      if (v.op != 2'b11) begin
         last_sign = v.es; last_mag = v.em; last_bcd = v.eb;
      end
      if (v.poke) begin
         // start during DONE must be dropped: nothing runs afterwards
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check({tag, " post_done_busy"}, busy, 1'b0);
         check({tag, " post_done_done"}, done, 1'b0);
         pulses = 0;
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
         end
         check({tag, " ignored_start"}, pulses, 0);
      end
   endtask

   initial begin
      vec_t rv;
      int   pulses;

      // Reset held two edges with start asserted
      ar = 1'b1; start = 1'b1; op = 2'b10;
      a_sign = 1'b0; a_mag = '1; b_sign = 1'b0; b_mag = '1;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset err", err, 1'b0);
      check("reset res_sign", res_sign, 1'b0);
      check("reset res_mag", res_mag, 0);
      check("reset bcd", bcd, 0);
      check("reset state", dbg.state, ST_IDLE);
      ar = 1'b0; start = 1'b0;
      @(negedge clk);
      check("idle after release busy", busy, 1'b0);
      check("idle after release state", dbg.state, ST_IDLE);
      last_sign = 1'b0; last_mag = '0; last_bcd = '0;

      // Directed vectors: op, A sign/mag, B sign/mag, poke, expected sign/mag/bcd/err
      add_vec(2'b00, 1'b0, 5, 1'b1, 7, 1'b0, 1'b1,  2, 'h02, 1'b0);
      add_vec(2'b00, 1'b0, 7, 1'b0, 7, 1'b0, 1'b0, 14, 'h14, 1'b0);
      add_vec(2'b01, 1'b1, 3, 1'b1, 3, 1'b0, 1'b0,  0, 'h00, 1'b0);
      add_vec(2'b00, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0,  0, 'h00, 1'b0);
      add_vec(2'b10, 1'b1, 7, 1'b0, 7, 1'b1, 1'b1, 49, 'h49, 1'b0);
      add_vec(2'b11, 1'b0, 1, 1'b0, 1, 1'b0, 1'b1, 49, 'h49, 1'b1);
      add_vec(2'b01, 1'b0, 2, 1'b1, 5, 1'b0, 1'b0,  7, 'h07, 1'b0);
      add_vec(2'b10, 1'b0, 6, 1'b1, 0, 1'b0, 1'b0,  0, 'h00, 1'b0);
      add_vec(2'b01, 1'b1, 2, 1'b0, 5, 1'b0, 1'b1,  7, 'h07, 1'b0);
      add_vec(2'b10, 1'b1, 5, 1'b1, 6, 1'b0, 1'b0, 30, 'h30, 1'b0);
      add_vec(2'b01, 1'b0, 0, 1'b0, 7, 1'b0, 1'b1,  7, 'h07, 1'b0);
      add_vec(2'b00, 1'b1, 4, 1'b0, 6, 1'b0, 1'b0,  2, 'h02, 1'b0);
      foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         rv.op = 2'($urandom_range(0, 3));
         rv.as = 1'($urandom_range(0, 1));
         rv.am = W'($urandom_range(0, (1 << W) - 1));
         rv.bs = 1'($urandom_range(0, 1));
         rv.bm = W'($urandom_range(0, (1 << W) - 1));
         rv.poke = 1'b0;
         model(rv.op, rv.as, rv.am, rv.bs, rv.bm, rv.es, rv.em, rv.eb, rv.ee);
         apply_vec(rv, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of a multiply
      @(negedge clk);
      op = 2'b10; a_sign = 1'b0; a_mag = 3'd7; b_sign = 1'b0; b_mag = 3'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      ar = 1'b1;
      @(negedge clk);
      check("midreset busy", busy, 1'b0);
      check("midreset done", done, 1'b0);
      check("midreset res_mag", res_mag, 0);
      check("midreset bcd", bcd, 0);
      check("midreset state", dbg.state, ST_IDLE);
      ar = 1'b0;
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("midreset no done", pulses, 0);
      last_sign = 1'b0; last_mag = '0; last_bcd = '0;
      rv.op = 2'b00; rv.as = 1'b0; rv.am = 3'd1; rv.bs = 1'b0; rv.bm = 3'd2; rv.poke = 1'b0;
      rv.es = 1'b0; rv.em = MAG_W'(3); rv.eb = BCD_W'('h03); rv.ee = 1'b0;
      apply_vec(rv, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
